// File: rtl/sorter_pkg.sv
// Shared types and helpers for the readout sorter / merger blocks.
package sorter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Ceiling log2 usable in parameter expressions; returns at least 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_merger_rr_pick.sv
// Rotating-priority encoder: first set request at or after base, wrapping N-1 -> 0.
module rr_pick
  import sorter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [W:0] s;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    s     = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, base} + (W+1)'(i);
      if (s >= (W+1)'(N)) s = s - (W+1)'(N);
      if (!valid && req[s[W-1:0]]) begin
        valid = 1'b1;
        idx   = s[W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rr_merger.sv
// Round-robin burst reader merging CNO standard-mode readout FIFOs into one output FIFO,
// tagging each forwarded word with its source channel.
module fifo_rr_merger
  import sorter_pkg::*;
#(
  parameter  int CNO        = 8,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 4,
  localparam int CW         = clog2(CNO)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [CNO*DATA_WIDTH-1:0] rdfifo_data_i,
  input  logic [CNO-1:0]            rdfifo_empty_i,
  output logic [CNO-1:0]            rdfifo_rden_o,
  output logic [DATA_WIDTH-1:0]     wrfifo_data_o,
  output logic [CW-1:0]             wrfifo_chan_o,
  output logic                      wrfifo_wren_o,
  input  logic                      wrfifo_prog_full_i,
  output logic                      busy_o,
  output logic [31:0]               word_cnt_o
);

  localparam int BCW = clog2(MAX_BURST + 1);

  state_e         state, state_nxt;
  logic [CW-1:0]  grant, grant_nxt;
  logic [CW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [BCW-1:0] burst_cnt, burst_cnt_nxt;
  logic [CW-1:0]  pick_idx;
  logic           pick_vld;
  logic           grant_empty;
  logic           rd;
  logic           wren_q;
  logic [CW-1:0]  rd_chan_q;
  logic [31:0]    word_cnt;

  rr_pick #(.N(CNO), .W(CW)) u_pick (
    .req   (~rdfifo_empty_i),
    .base  (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign grant_empty = rdfifo_empty_i[grant];

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    rd            = 1'b0;
    case (state)
      IDLE: begin
        if (en_i && pick_vld) begin
          grant_nxt     = pick_idx;
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        // Empty outranks prog_full: an empty channel ends the grant even while stalled.
        rd = en_i & ~grant_empty & ~wrfifo_prog_full_i;
        if (rd) burst_cnt_nxt = burst_cnt + BCW'(1);
        if (!en_i || grant_empty || (rd && burst_cnt_nxt == BCW'(MAX_BURST))) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (grant == CW'(CNO - 1)) ? '0 : grant + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdfifo_rden_o = '0;
    for (int c = 0; c < CNO; c++)
      rdfifo_rden_o[c] = rd && (grant == CW'(c));
  end

  // Source FIFO presents the popped word the cycle after rden, so the mux follows the registered channel.
  always_comb begin
    wrfifo_data_o = '0;
    for (int c = 0; c < CNO; c++)
      if (wren_q && rd_chan_q == CW'(c))
        wrfifo_data_o = rdfifo_data_i[c*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      wren_q    <= 1'b0;
      rd_chan_q <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
      wren_q    <= rd;
      if (rd) rd_chan_q <= grant;
      if (wren_q) word_cnt <= word_cnt + 32'd1;
    end
  end

  assign wrfifo_chan_o = rd_chan_q;
  assign wrfifo_wren_o = wren_q;
  assign busy_o        = (state == BURST) | wren_q;
  assign word_cnt_o    = word_cnt;

endmodule

// File: tb/tb_fifo_rr_merger.sv
// Directed bench for fifo_rr_merger: cycle tables plus hand sequences, with per-cycle
// scoreboard of channel order, read/write latency and read-enable gating.
module tb_fifo_rr_merger;
  import sorter_pkg::*;

  localparam int CNO = 8;
  localparam int DW  = 32;
  localparam int CW  = 3;

  typedef struct {
    logic       en;
    logic       pf;
    logic [7:0] rden;
    logic       wren;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pf = 1'b0;
  logic [CNO*DW-1:0] rd_data;
  logic [CNO-1:0]    empty, rden;
  logic [DW-1:0]     wr_data;
  logic [CW-1:0]     wr_chan;
  logic              wren, busy;
  logic [31:0]       word_cnt;

  logic [DW-1:0] mem [CNO][64];
  logic [DW-1:0] dout [CNO];
  int rd_cnt [CNO];
  int wr_cnt [CNO];
  int exp_idx [CNO];
  int nvec = 0;
  int nerr = 0;
  logic last_rd = 1'b0;
  logic [CW-1:0] last_ch = '0;

  always #5 clk = ~clk;

  fifo_rr_merger #(.CNO(CNO), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en_i               (en),
    .rdfifo_data_i      (rd_data),
    .rdfifo_empty_i     (empty),
    .rdfifo_rden_o      (rden),
    .wrfifo_data_o      (wr_data),
    .wrfifo_chan_o      (wr_chan),
    .wrfifo_wren_o      (wren),
    .wrfifo_prog_full_i (pf),
    .busy_o             (busy),
    .word_cnt_o         (word_cnt)
  );

  // Standard-mode source FIFO model: word appears on dout the cycle after rden.
  always_comb begin
    for (int c = 0; c < CNO; c++) begin
      empty[c] = (rd_cnt[c] == wr_cnt[c]);
      rd_data[c*DW +: DW] = dout[c];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < CNO; c++)
      if (rden[c]) begin
        dout[c]   <= mem[c][rd_cnt[c]];
        rd_cnt[c] <= rd_cnt[c] + 1;
      end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      mem[c][wr_cnt[c]] = {8'(c), 24'(wr_cnt[c])};
      wr_cnt[c]++;
    end
  endtask

  // Per-cycle invariants and scoreboard, sampled 1 time unit into the low phase.
  task automatic settle();
    #1;
    check("rden_onehot", 128'($onehot0(rden)), 128'(1));
    check("rden_gate", 128'(|(rden & (empty | {CNO{pf}}))), 128'(0));
    check("wren_latency", 128'(wren), 128'(last_rd));
    if (wren && last_rd) check("wren_chan", 128'(wr_chan), 128'(last_ch));
    if (wren) begin
      check("wren_data", 128'(wr_data), 128'(mem[wr_chan][exp_idx[wr_chan] % 64]));
      exp_idx[wr_chan]++;
    end
    last_rd = |rden;
    for (int c = 0; c < CNO; c++) if (rden[c]) last_ch = CW'(c);
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input string nm);
    en = v.en;
    pf = v.pf;
    settle();
    check(nm, 128'({rden, wren, busy}), 128'({v.rden, v.wren, v.busy}));
    adv();
  endtask

  task automatic resync();
    last_rd = 1'b0;
    for (int c = 0; c < CNO; c++) exp_idx[c] = rd_cnt[c];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    pf = 1'b0;
    adv();
    #1;
    check("reset_outputs", 128'({rden, wren, wr_chan, wr_data, busy, word_cnt}), 128'(0));
    rst_n = 1'b1;
    resync();
    @(negedge clk);
  endtask

  task automatic drain(input string nm, input int bound);
    int k;
    logic done;
    en = 1'b1;
    pf = 1'b0;
    done = 1'b0;
    for (k = 0; k < bound && !done; k++) begin
      settle();
      done = (empty == '1) && !busy;
      adv();
    end
    check({nm, "_timeout"}, 128'(done), 128'(1));
    for (int c = 0; c < CNO; c++) check({nm, "_drained"}, 128'(exp_idx[c]), 128'(wr_cnt[c]));
  endtask

  vec_t t1 [15];
  vec_t t4 [9];
  vec_t t5a [2];
  vec_t t5b [3];
  vec_t t6 [7];
  int seq [$];

  initial begin
    // One channel, 10 words: bursts 4,4,2 with an idle grant cycle between.
    t1 = '{'{1,0,8'h00,0,0}, '{1,0,8'h04,0,1}, '{1,0,8'h04,1,1}, '{1,0,8'h04,1,1},
           '{1,0,8'h04,1,1}, '{1,0,8'h00,1,1}, '{1,0,8'h04,0,1}, '{1,0,8'h04,1,1},
           '{1,0,8'h04,1,1}, '{1,0,8'h04,1,1}, '{1,0,8'h00,1,1}, '{1,0,8'h04,0,1},
           '{1,0,8'h04,1,1}, '{1,0,8'h00,1,1}, '{1,0,8'h00,0,0}};
    // prog_full for 3 cycles after two reads: count held, two more reads finish the burst.
    t4 = '{'{1,0,8'h00,0,0}, '{1,0,8'h08,0,1}, '{1,0,8'h08,1,1}, '{1,1,8'h00,1,1},
           '{1,1,8'h00,0,1}, '{1,1,8'h00,0,1}, '{1,0,8'h08,0,1}, '{1,0,8'h08,1,1},
           '{1,0,8'h00,1,1}};
    t5a = '{'{1,0,8'h00,0,0}, '{1,0,8'h20,0,1}};
    t5b = '{'{1,1,8'h00,1,1}, '{1,0,8'h00,0,0}, '{1,0,8'h40,0,1}};
    t6 = '{'{1,0,8'h00,0,0}, '{1,0,8'h02,0,1}, '{1,0,8'h02,1,1}, '{0,0,8'h00,1,1},
           '{0,0,8'h00,0,0}, '{0,0,8'h00,0,0}, '{1,0,8'h00,0,0}};

    do_reset();
    push(2, 10);
    for (int i = 0; i < 15; i++) apply(t1[i], $sformatf("t1_row%0d", i));
    check("t1_word_cnt", 128'(word_cnt), 128'(10));

    // All channels one word each: served in ascending order.
    do_reset();
    for (int c = 0; c < CNO; c++) push(c, 1);
    en = 1'b1;
    seq.delete();
    for (int k = 0; k < 40; k++) begin
      settle();
      if (wren) seq.push_back(int'(wr_chan));
      adv();
    end
    check("t2_count", 128'(seq.size()), 128'(8));
    for (int i = 0; i < 8 && i < seq.size(); i++) check($sformatf("t2_order%0d", i), 128'(seq[i]), 128'(i));
    check("t2_word_cnt", 128'(word_cnt), 128'(8));

    // Two busy channels alternate in 4-word grants.
    do_reset();
    push(0, 20);
    push(1, 20);
    en = 1'b1;
    seq.delete();
    for (int k = 0; k < 40; k++) begin
      settle();
      if (wren) seq.push_back(int'(wr_chan));
      adv();
    end
    check("t3_count", 128'(seq.size() >= 16), 128'(1));
    for (int i = 0; i < 16 && i < seq.size(); i++) check($sformatf("t3_grant%0d", i), 128'(seq[i]), 128'((i / 4) % 2));
    drain("t3", 200);

    do_reset();
    push(3, 8);
    for (int i = 0; i < 9; i++) apply(t4[i], $sformatf("t4_row%0d", i));
    drain("t4", 100);
    check("t4_word_cnt", 128'(word_cnt), 128'(8));

    // Channel runs dry with prog_full high: grant ends, pointer moves to ch6 ahead of ch4.
    do_reset();
    push(5, 1);
    for (int i = 0; i < 2; i++) apply(t5a[i], $sformatf("t5_row%0d", i));
    push(4, 1);
    push(6, 1);
    for (int i = 0; i < 3; i++) apply(t5b[i], $sformatf("t5_row%0d", i + 2));
    drain("t5", 100);

    // en drop mid-burst, then reset while a read is being issued.
    do_reset();
    push(1, 8);
    for (int i = 0; i < 7; i++) apply(t6[i], $sformatf("t6_row%0d", i));
    en = 1'b1;
    settle();
    check("t6_rden_before_rst", 128'(rden), 128'(8'h02));
    rst_n = 1'b0;
    #1;
    check("t6_outputs_in_rst", 128'({rden, wren, wr_chan, wr_data, busy, word_cnt}), 128'(0));
    adv();
    #1;
    check("t6_word_cnt_rst", 128'(word_cnt), 128'(0));
    rst_n = 1'b1;
    resync();
    @(negedge clk);
    drain("t6", 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
